gcd_unit_arbiter: RTL
=====================

// Module: gcd_unit_arbiter
// PURPOSE
//  Shares one GCD unit (32b {a,b} request stream, 16b result stream) among
//  p_nreqs requesters. Round-robin picks one valid request per transfer,
//  records the winner's index in an in-order tag FIFO, and steers each GCD
//  result back to the requester at the FIFO head. Sits between requester
//  val/rdy ports and the GCD unit's istream/ostream.
// PARAMETERS
//  p_nreqs   4  number of requesters (>=2)
//  p_ntags   2  tag FIFO depth = max requests in flight inside the GCD unit
// PORTS
//  clk             in   1          sole clock, rising edge
//  reset           in   1          asynchronous, active-low reset
//  req_val         in   p_nreqs    per-requester request valid
//  req_rdy         out  p_nreqs    per-requester request ready
//  req_msg         in   32*p_nreqs requester i msg at [32*i+31:32*i], {a,b}
//  resp_val        out  p_nreqs    per-requester result valid
//  resp_rdy        in   p_nreqs    per-requester result ready
//  resp_msg        out  16         result, broadcast to all requesters
//  gcd_req_val     out  1          to GCD istream_val
//  gcd_req_rdy     in   1          from GCD istream_rdy
//  gcd_req_msg     out  32         to GCD istream_msg
//  gcd_resp_val    in   1          from GCD ostream_val
//  gcd_resp_rdy    out  1          to GCD ostream_rdy
//  gcd_resp_msg    in   16         from GCD ostream_msg
//  occupancy       out  clog2(p_ntags+1)  tags currently in flight
//  err_orphan      out  1          sticky: GCD result seen with no tag
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low. While reset is low:
//    rr_ptr=0, FIFO empty, occupancy=0, err_orphan=0; all val/rdy outputs 0.
//  - Tag width = max(1,clog2(p_nreqs)). full = (occupancy==p_ntags).
//  - Grant (combinational): first i with req_val[i]=1 scanning
//    rr_ptr, rr_ptr+1, ... wrapping mod p_nreqs. One-hot or zero.
//  - gcd_req_val = |req_val && !full; gcd_req_msg = req_msg of grantee.
//  - req_rdy[i] = grant[i] && gcd_req_rdy && !full; others 0.
//  - Issue fire (gcd_req_val && gcd_req_rdy): push grantee index; rr_ptr <=
//    (grantee+1) mod p_nreqs. No fire: rr_ptr holds. Zero-cycle latency.
//  - Full: no issue, even if a pop occurs the same cycle (no bypass).
//  - Return: head = FIFO head tag. resp_val[head] = gcd_resp_val && !empty,
//    other resp_val 0; gcd_resp_rdy = resp_rdy[head] && !empty;
//    resp_msg = gcd_resp_msg. Return fire pops head. Results in issue order.
//  - Empty: gcd_resp_rdy=0; gcd_resp_val=1 while empty sets err_orphan
//    (cleared only by reset).
//  - Same-cycle push+pop (not full): occupancy unchanged, both act.
//  - No val depends on any rdy (no combinational loops).
//  - Pointers wrap mod p_ntags; occupancy never exceeds p_ntags nor < 0.
//  - Reset mid-operation: tags dropped; GCD unit shares reset, so in-flight
//    work is discarded; nothing delivered after reset release.
//  - Requester holding req_val may lose grant to others; starvation bound:
//    granted within p_nreqs issue fires.
// TESTING
//  1 Single req0 {0x000f,0x0005}, GCD model -> resp_val[0]=1, resp_msg=0x0005.
//  2 All 4 req_val held, gcd_req_rdy=1 -> grant order 0,1,2,3,0; results
//    return to 0,1,2,3 in order.
//  3 p_ntags=2, resp_rdy=0 -> third request stalls (req_rdy=0,
//    gcd_req_val=0, occupancy=2) until one result popped.
//  4 Head tag=2, resp_rdy[2]=0, resp_rdy[0]=1 -> gcd_resp_rdy=0, no pop.
//  5 Inject gcd_resp_val=1 with FIFO empty -> err_orphan=1 and stays 1.
//  6 Assert reset low with 2 in flight -> next cycle occupancy=0, all
//    outputs 0; after release req3 alone is granted first-scan from rr_ptr=0.

Source files
------------

// File: rtl/gcd_unit_arbiter.sv
// Shares one GCD unit among p_nreqs requesters with round-robin issue
// and an in-order tag FIFO that steers each result to its requester.
//
// Ports:
//   clk, reset        clock and asynchronous active-low reset
//   req_val/rdy/msg   per-requester request streams, msg {a,b} 32b each
//   resp_val/rdy      per-requester result handshake
//   resp_msg          16b result, broadcast to all requesters
//   gcd_req_*         istream of the shared GCD unit
//   gcd_resp_*        ostream of the shared GCD unit
//   occupancy         tags currently in flight
//   err_orphan        sticky: GCD result arrived with no tag outstanding
module gcd_unit_arbiter #(
  parameter  int p_nreqs = 4,
  parameter  int p_ntags = 2,
  localparam int TW = (p_nreqs > 1) ? $clog2(p_nreqs) : 1,
  localparam int PW = (p_ntags > 1) ? $clog2(p_ntags) : 1,
  localparam int OW = $clog2(p_ntags + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [p_nreqs-1:0]     req_val,
  output logic [p_nreqs-1:0]     req_rdy,
  input  logic [32*p_nreqs-1:0]  req_msg,
  output logic [p_nreqs-1:0]     resp_val,
  input  logic [p_nreqs-1:0]     resp_rdy,
  output logic [15:0]            resp_msg,
  output logic                   gcd_req_val,
  input  logic                   gcd_req_rdy,
  output logic [31:0]            gcd_req_msg,
  input  logic                   gcd_resp_val,
  output logic                   gcd_resp_rdy,
  input  logic [15:0]            gcd_resp_msg,
  output logic [OW-1:0]          occupancy,
  output logic                   err_orphan
);

  logic [TW-1:0] rr_q, rr_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          err_q, err_d;
  logic [TW-1:0] tags_q [p_ntags];

  logic [p_nreqs-1:0] grant;
  logic [TW-1:0]      gidx;
  logic               found;
  logic               full;
  logic               empty;
  logic [TW-1:0]      head;
  logic               issue;
  logic               pop;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    if (p == PW'(p_ntags - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // First valid requester scanning upward from rr_q with wrap.
  always_comb begin
    gidx  = '0;
    found = 1'b0;
    for (int k = 0; k < p_nreqs; k++) begin
      if (!found &&
          req_val[(int'(rr_q) + k) % p_nreqs]) begin
        found = 1'b1;
        gidx  = TW'((int'(rr_q) + k) % p_nreqs);
      end
    end
  end

  assign grant = found ? (p_nreqs'(1) << gidx) : '0;

  assign full  = (occ_q == OW'(p_ntags));
  assign empty = (occ_q == '0);
  assign head  = tags_q[rd_q];

  // Outputs are gated by reset so every val/rdy is 0 while it is held.
  assign gcd_req_val = reset && (|req_val) && !full;
  assign gcd_req_msg = req_msg[32*gidx +: 32];

  assign req_rdy = (reset && gcd_req_rdy && !full) ?
                   grant : '0;

  assign resp_val = (reset && gcd_resp_val && !empty) ?
                    (p_nreqs'(1) << head) : '0;

  assign gcd_resp_rdy = reset && !empty && resp_rdy[head];
  assign resp_msg     = gcd_resp_msg;

  assign issue = gcd_req_val && gcd_req_rdy;
  assign pop   = gcd_resp_val && gcd_resp_rdy;

  always_comb begin
    rr_d  = rr_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    err_d = err_q;
    if (issue) begin
      rr_d = (gidx == TW'(p_nreqs - 1)) ? '0 : gidx + 1'b1;
      wr_d = ptr_inc(wr_q);
    end
    if (pop) begin
      rd_d = ptr_inc(rd_q);
    end
    unique case (1'b1)
      issue && !pop: occ_d = occ_q + 1'b1;
      pop && !issue: occ_d = occ_q - 1'b1;
      default:       occ_d = occ_q;
    endcase
    if (gcd_resp_val && empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q  <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
      err_q <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
      err_q <= err_d;
    end
  end

  // Tag storage needs no reset: entries are only read when occupied.
  always_ff @(posedge clk) begin
    if (issue) begin
      tags_q[wr_q] <= gidx;
    end
  end

  assign occupancy  = occ_q;
  assign err_orphan = err_q;

endmodule
